// File: rtl/vga_fb_pkg.sv
// Shared definitions for the UART-to-frame-buffer write path: FSM states,
// pixel formats, default frame marker and a constant-foldable clog2.
package vga_fb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } fb_state_e;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'h55;
    localparam int unsigned PIX_RGB332        = 1;
    localparam int unsigned PIX_RGB565        = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        n = 0;
        v = value - 1;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts while enabled, restarts on every byte, and
// flags the last permitted idle cycle unless a byte arrives in that cycle.
module uart_gap_timer
    import vga_fb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 200_000
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        expire = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));
        cnt_d  = (!enable || clear || expire) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_fb_writer.sv
// Assembles SYNC-framed UART pixel streams into raster-ordered writes to the
// back half of a double-buffered frame RAM; the display buffer flips per frame.
module uart_fb_writer
    import vga_fb_pkg::*;
#(
    parameter  int unsigned IMG_W     = 100,
    parameter  int unsigned IMG_H     = 100,
    parameter  int unsigned PIX_BYTES = 1,
    parameter  logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter  int unsigned TIMEOUT   = 200_000,
    localparam int unsigned NPIX      = IMG_W * IMG_H,
    localparam int unsigned AW        = clog2(NPIX)
) (
    input  logic                   sclk,
    input  logic                   rst_n,
    input  logic                   pi_flag,
    input  logic [7:0]             pi_data,
    output logic                   wr_en,
    output logic [AW:0]            wr_addr,
    output logic [8*PIX_BYTES-1:0] wr_data,
    output logic                   disp_buf,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   err_timeout
);

    fb_state_e              state_q;
    logic [AW-1:0]          pix_cnt_q;
    logic                   byte_cnt_q;
    logic                   wr_en_q;
    logic [AW:0]            wr_addr_q;
    logic [8*PIX_BYTES-1:0] wr_data_q;
    logic                   disp_buf_q;
    logic                   frame_done_q;
    logic                   err_timeout_q;
    logic [8*PIX_BYTES-1:0] pixel;
    logic                   last_byte;
    logic                   expire;

    uart_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .enable (state_q == ST_RECV),
        .clear  (pi_flag),
        .expire (expire)
    );

    // Byte assembly: RGB565 latches the MSB and completes on the second byte.
    if (PIX_BYTES == PIX_RGB565) begin : g_rgb565
        logic [7:0] msb_q;

        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
                msb_q <= '0;
            end else if (state_q == ST_RECV && pi_flag && !byte_cnt_q) begin
                msb_q <= pi_data;
            end
        end

        assign pixel     = {msb_q, pi_data};
        assign last_byte = byte_cnt_q;
    end else if (PIX_BYTES == PIX_RGB332) begin : g_rgb332
        assign pixel     = pi_data;
        assign last_byte = 1'b1 | byte_cnt_q;
    end else begin : g_illegal_pix_bytes
        $error("uart_fb_writer: PIX_BYTES must be 1 or 2");
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            byte_cnt_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            disp_buf_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pi_flag && pi_data == SYNC_BYTE) begin
                        state_q    <= ST_RECV;
                        pix_cnt_q  <= '0;
                        byte_cnt_q <= 1'b0;
                    end
                end
                ST_RECV: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (pi_flag) begin
                        if (!last_byte) begin
                            byte_cnt_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= {~disp_buf_q, pix_cnt_q};
                            wr_data_q  <= pixel;
                            if (pix_cnt_q == AW'(NPIX - 1)) begin
                                frame_done_q <= 1'b1;
                                disp_buf_q   <= ~disp_buf_q;
                                pix_cnt_q    <= '0;
                                state_q      <= ST_IDLE;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + 1'b1;
                            end
                        end
                    end else if (expire) begin
                        err_timeout_q <= 1'b1;
                        byte_cnt_q    <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign disp_buf    = disp_buf_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q == ST_RECV);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_fb_writer.sv
// Bench for uart_fb_writer: an RGB332 4x2 instance and an RGB565 2x1 instance,
// both with a 16-cycle gap limit, checked against a frame-level model.
module tb_uart_fb_writer;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        flag1, flag2;
    logic [7:0]  data1, data2;

    logic        wr_en1, disp1, fd1, busy1, err1;
    logic [3:0]  wr_addr1;
    logic [7:0]  wr_data1;
    logic        wr_en2, disp2, fd2, busy2, err2;
    logic [1:0]  wr_addr2;
    logic [15:0] wr_data2;

    int tests = 0;
    int fails = 0;

    uart_fb_writer #(
        .IMG_W     (4),
        .IMG_H     (2),
        .PIX_BYTES (1),
        .SYNC_BYTE (8'h55),
        .TIMEOUT   (TMO)
    ) dut1 (
        .sclk        (clk),
        .rst_n       (rst_n),
        .pi_flag     (flag1),
        .pi_data     (data1),
        .wr_en       (wr_en1),
        .wr_addr     (wr_addr1),
        .wr_data     (wr_data1),
        .disp_buf    (disp1),
        .frame_done  (fd1),
        .busy        (busy1),
        .err_timeout (err1)
    );

    uart_fb_writer #(
        .IMG_W     (2),
        .IMG_H     (1),
        .PIX_BYTES (2),
        .SYNC_BYTE (8'h55),
        .TIMEOUT   (TMO)
    ) dut2 (
        .sclk        (clk),
        .rst_n       (rst_n),
        .pi_flag     (flag2),
        .pi_data     (data2),
        .wr_en       (wr_en2),
        .wr_addr     (wr_addr2),
        .wr_data     (wr_data2),
        .disp_buf    (disp2),
        .frame_done  (fd2),
        .busy        (busy2),
        .err_timeout (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    typedef struct {
        bit         in_frame;
        int         pend_n;
        logic [7:0] msb;
        int         pix;
        bit         disp;
        int         idle;
        bit         wr_en;
        int         addr;
        int         data;
        bit         fd;
        bit         err;
    } model_t;

    model_t m1, m2;

    function automatic model_t model_reset();
        model_t m;
        m.in_frame = 0; m.pend_n = 0; m.msb = 8'h00; m.pix = 0; m.disp = 0;
        m.idle = 0; m.wr_en = 0; m.addr = 0; m.data = 0; m.fd = 0; m.err = 0;
        return m;
    endfunction

    function automatic model_t step(input model_t mi, input bit flag, input logic [7:0] d,
                                    input int pb, input int npix, input int aw);
        model_t m;
        m = mi;
        m.wr_en = 0;
        m.fd    = 0;
        m.err   = 0;
        if (!m.in_frame) begin
            if (flag && d == 8'h55) begin
                m.in_frame = 1; m.pend_n = 0; m.pix = 0; m.idle = 0;
            end
        end else if (flag) begin
            m.idle = 0;
            if (pb == 2 && m.pend_n == 0) begin
                m.msb    = d;
                m.pend_n = 1;
            end else begin
                m.data   = (pb == 2) ? int'(m.msb) * 256 + int'(d) : int'(d);
                m.pend_n = 0;
                m.wr_en  = 1;
                m.addr   = (m.disp ? 0 : (1 << aw)) + m.pix;
                m.pix    = m.pix + 1;
                if (m.pix == npix) begin
                    m.fd       = 1;
                    m.disp     = !m.disp;
                    m.in_frame = 0;
                end
            end
        end else begin
            m.idle = m.idle + 1;
            if (m.idle == TMO) begin
                m.err      = 1;
                m.in_frame = 0;
            end
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= model_reset();
            m2 <= model_reset();
        end else begin
            m1 <= step(m1, flag1, data1, 1, 8, 3);
            m2 <= step(m2, flag2, data2, 2, 2, 1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m1.wr_en", int'(wr_en1), int'(m1.wr_en));
        if (m1.wr_en) begin
            chk("m1.wr_addr", int'(wr_addr1), m1.addr);
            chk("m1.wr_data", int'(wr_data1), m1.data);
        end
        chk("m1.frame_done", int'(fd1), int'(m1.fd));
        chk("m1.err_timeout", int'(err1), int'(m1.err));
        chk("m1.busy", int'(busy1), int'(m1.in_frame));
        chk("m1.disp_buf", int'(disp1), int'(m1.disp));
        chk("m2.wr_en", int'(wr_en2), int'(m2.wr_en));
        if (m2.wr_en) begin
            chk("m2.wr_addr", int'(wr_addr2), m2.addr);
            chk("m2.wr_data", int'(wr_data2), m2.data);
        end
        chk("m2.frame_done", int'(fd2), int'(m2.fd));
        chk("m2.err_timeout", int'(err2), int'(m2.err));
        chk("m2.busy", int'(busy2), int'(m2.in_frame));
        chk("m2.disp_buf", int'(disp2), int'(m2.disp));
    end

    // ---------------- stimulus ----------------
    task automatic send(input int which, input logic [7:0] d);
        if (which == 1) begin
            flag1 = 1'b1; data1 = d;
        end else begin
            flag2 = 1'b1; data2 = d;
        end
        @(negedge clk);
        flag1 = 1'b0;
        flag2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, ".wr_en"}, int'(wr_en1), 0);
        chk({tag, ".wr_addr"}, int'(wr_addr1), 0);
        chk({tag, ".wr_data"}, int'(wr_data1), 0);
        chk({tag, ".disp_buf"}, int'(disp1), 0);
        chk({tag, ".frame_done"}, int'(fd1), 0);
        chk({tag, ".busy"}, int'(busy1), 0);
        chk({tag, ".err_timeout"}, int'(err1), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         wr_en;
        int         addr;
        int         data;
        bit         fd;
        bit         disp;
        bit         busy;
    } vec_t;

    vec_t tbl[18];
    int   k;
    bit   seen;
    int unsigned r1, r2;
    int   sil1, sil2;

    initial begin
        tbl[0] = '{8'h55, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{8'(i), 1'b1, 7 + i, i, (i == 8), (i == 8), (i != 8)};
        tbl[9] = '{8'h55, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[10 + i] = '{8'hA0 + 8'(i), 1'b1, i, 'hA0 + i, (i == 7), (i != 7), (i != 7)};

        rst_n = 1'b0;
        flag1 = 1'b0; flag2 = 1'b0;
        data1 = 8'h00; data2 = 8'h00;
        idle(2);
        chk_zero1("reset");
        chk("reset.wr_data2", int'(wr_data2), 0);
        chk("reset.busy2", int'(busy2), 0);
        rst_n = 1'b1;
        idle(1);

        // Two back-to-back RGB332 frames: buffer 1 then buffer 0.
        for (int i = 0; i < 18; i++) begin
            send(1, tbl[i].d);
            chk($sformatf("tbl[%0d].wr_en", i), int'(wr_en1), int'(tbl[i].wr_en));
            if (tbl[i].wr_en) begin
                chk($sformatf("tbl[%0d].wr_addr", i), int'(wr_addr1), tbl[i].addr);
                chk($sformatf("tbl[%0d].wr_data", i), int'(wr_data1), tbl[i].data);
            end
            chk($sformatf("tbl[%0d].frame_done", i), int'(fd1), int'(tbl[i].fd));
            chk($sformatf("tbl[%0d].disp_buf", i), int'(disp1), int'(tbl[i].disp));
            chk($sformatf("tbl[%0d].busy", i), int'(busy1), int'(tbl[i].busy));
        end

        // RGB565 2x1 frame.
        send(2, 8'h55);
        send(2, 8'h12);
        chk("rgb565.first_byte_no_write", int'(wr_en2), 0);
        send(2, 8'h34);
        chk("rgb565.p0.wr_en", int'(wr_en2), 1);
        chk("rgb565.p0.wr_addr", int'(wr_addr2), 2);
        chk("rgb565.p0.wr_data", int'(wr_data2), 'h1234);
        send(2, 8'h56);
        chk("rgb565.msb_no_write", int'(wr_en2), 0);
        send(2, 8'h78);
        chk("rgb565.p1.wr_en", int'(wr_en2), 1);
        chk("rgb565.p1.wr_addr", int'(wr_addr2), 3);
        chk("rgb565.p1.wr_data", int'(wr_data2), 'h5678);
        chk("rgb565.frame_done", int'(fd2), 1);
        chk("rgb565.disp_buf", int'(disp2), 1);

        // Silence after two pixels: timeout on the 16th idle cycle.
        send(1, 8'h55);
        send(1, 8'h01);
        send(1, 8'h02);
        seen = 0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (err1) seen = 1;
        end
        chk("timeout.idle_cycles", k, TMO);
        chk("timeout.busy", int'(busy1), 0);
        chk("timeout.disp_buf", int'(disp1), 0);
        send(1, 8'h01);
        chk("timeout.after_ignored", int'(wr_en1), 0);
        chk("timeout.after_idle", int'(busy1), 0);

        // Stray idle bytes, SYNC value as pixel data, byte in the expiry cycle.
        send(1, 8'h00);
        send(1, 8'hFF);
        chk("stray.busy", int'(busy1), 0);
        send(1, 8'h55);
        for (int i = 0; i < 3; i++) begin
            send(1, 8'h55);
            chk($sformatf("sync_data[%0d].wr_data", i), int'(wr_data1), 'h55);
            chk($sformatf("sync_data[%0d].wr_addr", i), int'(wr_addr1), 8 + i);
        end
        idle(TMO - 1);
        send(1, 8'h55);
        chk("expiry_byte.err", int'(err1), 0);
        chk("expiry_byte.wr_en", int'(wr_en1), 1);
        chk("expiry_byte.wr_addr", int'(wr_addr1), 11);
        chk("expiry_byte.busy", int'(busy1), 1);
        for (int i = 0; i < 4; i++) send(1, 8'h55);
        chk("sync_last.frame_done", int'(fd1), 1);
        chk("sync_last.wr_addr", int'(wr_addr1), 15);
        chk("sync_last.disp_buf", int'(disp1), 1);
        send(1, 8'h01);
        chk("sync_last.no_restart", int'(busy1), 0);

        // Asynchronous reset in the middle of a frame.
        send(1, 8'h55);
        send(1, 8'h01);
        send(1, 8'h02);
        send(1, 8'h03);
        #3 rst_n = 1'b0;
        #1 chk_zero1("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 8'h55);
        for (int i = 1; i <= 8; i++) begin
            send(1, 8'(i));
            chk($sformatf("post_reset[%0d].wr_addr", i), int'(wr_addr1), 7 + i);
        end
        chk("post_reset.frame_done", int'(fd1), 1);
        chk("post_reset.disp_buf", int'(disp1), 1);

        // Randomised traffic with occasional long silences; model checks every cycle.
        sil1 = 0;
        sil2 = 0;
        for (int c = 0; c < 4000; c++) begin
            if (sil1 > 0) begin
                sil1--;
                flag1 = 1'b0;
            end else begin
                r1 = $urandom_range(0, 99);
                if (r1 < 3) sil1 = int'($urandom_range(TMO - 2, TMO + 2));
                flag1 = (r1 >= 3 && r1 < 60);
                data1 = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
            end
            if (sil2 > 0) begin
                sil2--;
                flag2 = 1'b0;
            end else begin
                r2 = $urandom_range(0, 99);
                if (r2 < 3) sil2 = int'($urandom_range(TMO - 2, TMO + 2));
                flag2 = (r2 >= 3 && r2 < 60);
                data2 = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
            end
            @(negedge clk);
        end
        flag1 = 1'b0;
        flag2 = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
